// File: rtl/pattern_count_engine_if.sv
// pattern_count_engine_if: memory-side handshake bundle for pattern_count_engine
// start/done  : one-cycle run request and completion level
// rd_addr/rd_data : combinational read port (data valid in the same cycle)
// wr_en/wr_addr/wr_data : registered write port
interface pattern_count_engine_if;
    logic       start;
    logic       done;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    modport master (output start, rd_data, input done, rd_addr, wr_en, wr_addr, wr_data);
    modport slave  (input start, rd_data, output done, rd_addr, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/pattern_count_engine.sv
// pattern_count_engine: counts 5-bit pattern hits in a 32-byte message and writes three totals back
// clk   : rising-edge clock
// reset : synchronous active-high, clears all state
// bus   : slave side of pattern_count_engine_if (start/done, read port, write port)
module pattern_count_engine #(
    parameter logic [7:0] MSG_BASE = 8'd0,
    parameter int         MSG_LEN  = 32,
    parameter logic [7:0] PAT_ADDR = 8'd32,
    parameter logic [7:0] OUT_ADDR = 8'd33
) (
    input logic clk,
    input logic reset,
    pattern_count_engine_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LDPAT, SCAN, WR0, WR1, WR2, DONE} state_t;
    state_t     state_q;
    logic [4:0] idx_q, pat_q;
    logic [7:0] prev_q, ctb_q, cts_q, ctb_d, cts_d;
    logic [5:0] cto_q, cto_d;
    logic       done_q, wr_en_q;
    logic [7:0] wr_addr_q, wr_data_q;
    logic [15:0] win;
    logic [2:0] inb;
    logic [3:0] crs;
    logic       last;
    assign last = idx_q == 5'(MSG_LEN - 1);
    // inb: windows starting inside the current byte; crs: windows starting in the previous byte
    always_comb begin
        win = {prev_q, bus.rd_data};
        inb = '0;
        crs = '0;
        for (int k = 0; k < 4; k++) inb = inb + {2'b0, bus.rd_data[k +: 5] == pat_q};
        for (int k = 0; k < 8; k++) crs = crs + {3'b0, win[15 - k -: 5] == pat_q};
        ctb_d = ctb_q + {5'b0, inb};
        cto_d = cto_q + {5'b0, inb != 3'd0};
        // the last byte has no successor, so its own in-byte windows close out the crossing count
        cts_d = cts_q + (idx_q != 5'd0 ? {4'b0, crs} : 8'd0) + (last ? {5'b0, inb} : 8'd0);
    end
    assign bus.rd_addr = state_q == LDPAT ? PAT_ADDR : state_q == SCAN ? MSG_BASE + {3'b0, idx_q} : 8'd0;
    assign bus.done    = done_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pat_q     <= '0;
            prev_q    <= '0;
            ctb_q     <= '0;
            cto_q     <= '0;
            cts_q     <= '0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                IDLE, DONE: if (bus.start) begin
                    ctb_q   <= '0;
                    cto_q   <= '0;
                    cts_q   <= '0;
                    idx_q   <= '0;
                    prev_q  <= '0;
                    done_q  <= 1'b0;
                    state_q <= LDPAT;
                end
                LDPAT: begin
                    pat_q   <= bus.rd_data[7:3];
                    state_q <= SCAN;
                end
                SCAN: begin
                    ctb_q   <= ctb_d;
                    cto_q   <= cto_d;
                    cts_q   <= cts_d;
                    prev_q  <= bus.rd_data;
                    idx_q   <= idx_q + 5'd1;
                    state_q <= last ? WR0 : SCAN;
                end
                WR0: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= OUT_ADDR;
                    wr_data_q <= ctb_q;
                    state_q   <= WR1;
                end
                WR1: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= OUT_ADDR + 8'd1;
                    wr_data_q <= {2'b0, cto_q};
                    state_q   <= WR2;
                end
                WR2: begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= OUT_ADDR + 8'd2;
                    wr_data_q <= cts_q;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
